// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PREP  = 3'd1,
      ITER  = 3'd2,
      FIXUP = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Handshake/result bundle between the execute stage (master) and the divider (slave).
interface div_sequencer_if
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);

   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] divisionHIRes;
   logic [WIDTH-1:0] divisionLOQuo;
   logic             div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, divisionHIRes, divisionLOQuo, div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, divisionHIRes, divisionLOQuo, div_by_zero
   );

endinterface

// File: rtl/div_step.sv
// One restoring shift/trial-subtract step on unsigned magnitudes.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic [WIDTH-1:0] i_quo,
   input  logic [WIDTH-1:0] i_dmag,
   output logic [WIDTH-1:0] o_rem,
   output logic [WIDTH-1:0] o_quo
);

   logic [WIDTH:0] w_shift;
   logic [WIDTH:0] w_diff;

   // Shift {R,Q} left, subtract divisor from R; MSB of the wide difference is the borrow.
   always_comb begin
      w_shift = {i_rem, i_quo[WIDTH-1]};
      w_diff  = w_shift - {1'b0, i_dmag};
      if (w_diff[WIDTH] == 1'b0) begin
         o_rem = w_diff[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b1};
      end else begin
         o_rem = w_shift[WIDTH-1:0];
         o_quo = {i_quo[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/div_sequencer.sv
// Fixed-latency DIV/DIVU sequencer: IDLE -> PREP -> ITER x WIDTH -> FIXUP -> DONE.
module div_sequencer
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic           clk,
   input  logic           reset,
   div_sequencer_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           r_state;
   state_t           w_next_state;

   logic [WIDTH-1:0] r_dividend;
   logic [WIDTH-1:0] r_divisor;
   logic             r_signed;
   logic             r_ds;
   logic             r_vs;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dmag;
   logic [CW-1:0]    r_cnt;

   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_dbz;

   logic [WIDTH-1:0] w_dd_mag;
   logic [WIDTH-1:0] w_dv_mag;
   logic [WIDTH-1:0] w_step_rem;
   logic [WIDTH-1:0] w_step_quo;
   logic [WIDTH-1:0] w_fix_hi;
   logic [WIDTH-1:0] w_fix_lo;
   logic             w_fix_dbz;

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem  (r_rem),
      .i_quo  (r_quo),
      .i_dmag (r_dmag),
      .o_rem  (w_step_rem),
      .o_quo  (w_step_quo)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_next_state = PREP;
            end else begin
               w_next_state = IDLE;
            end
         end
         PREP: w_next_state = ITER;
         ITER: begin
            if (r_cnt == CW'(WIDTH - 1)) begin
               w_next_state = FIXUP;
            end else begin
               w_next_state = ITER;
            end
         end
         FIXUP:   w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // Operand magnitudes and final sign/zero fixup; divide by zero bypasses the sign fix.
   always_comb begin
      w_dd_mag = (r_signed && r_ds) ? -r_dividend : r_dividend;
      w_dv_mag = (r_signed && r_vs) ? -r_divisor  : r_divisor;
      if (r_divisor == {WIDTH{1'b0}}) begin
         w_fix_lo  = {WIDTH{1'b1}};
         w_fix_hi  = r_dividend;
         w_fix_dbz = 1'b1;
      end else begin
         w_fix_lo  = (r_signed && (r_ds != r_vs)) ? -r_quo : r_quo;
         w_fix_hi  = (r_signed && r_ds) ? -r_rem : r_rem;
         w_fix_dbz = 1'b0;
      end
   end

   // Datapath: latch on accept, iterate, and publish results in FIXUP.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dividend <= {WIDTH{1'b0}};
         r_divisor  <= {WIDTH{1'b0}};
         r_signed   <= 1'b0;
         r_ds       <= 1'b0;
         r_vs       <= 1'b0;
         r_rem      <= {WIDTH{1'b0}};
         r_quo      <= {WIDTH{1'b0}};
         r_dmag     <= {WIDTH{1'b0}};
         r_cnt      <= {CW{1'b0}};
         r_hi       <= {WIDTH{1'b0}};
         r_lo       <= {WIDTH{1'b0}};
         r_dbz      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_dividend <= bus.dividend;
                  r_divisor  <= bus.divisor;
                  r_signed   <= bus.is_signed;
                  r_ds       <= bus.dividend[WIDTH-1];
                  r_vs       <= bus.divisor[WIDTH-1];
               end
            end
            PREP: begin
               r_rem  <= {WIDTH{1'b0}};
               r_quo  <= w_dd_mag;
               r_dmag <= w_dv_mag;
               r_cnt  <= {CW{1'b0}};
            end
            ITER: begin
               r_rem <= w_step_rem;
               r_quo <= w_step_quo;
               r_cnt <= r_cnt + CW'(1);
            end
            FIXUP: begin
               r_hi  <= w_fix_hi;
               r_lo  <= w_fix_lo;
               r_dbz <= w_fix_dbz;
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // Registered handshake flags derived from the upcoming state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= (w_next_state == PREP) || (w_next_state == ITER) || (w_next_state == FIXUP);
         r_done <= (w_next_state == DONE);
      end
   end

   assign bus.busy          = r_busy;
   assign bus.done          = r_done;
   assign bus.divisionHIRes = r_hi;
   assign bus.divisionLOQuo = r_lo;
   assign bus.div_by_zero   = r_dbz;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: vector table plus protocol and reset sequences.
module tb_div_sequencer;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   div_sequencer_if #(.WIDTH(32)) bus ();

   div_sequencer #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] dd;
      logic [31:0] dv;
      logic [31:0] lo;
      logic [31:0] hi;
      logic        dbz;
   } vec_t;

   vec_t vecs[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Issue one op; glitch>0 pulses start with other operands in that cycle.
   task automatic run_op(input logic sgn, input logic [31:0] dd, input logic [31:0] dv,
                         input int glitch, output int lat, output int busy_cnt);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.is_signed = sgn;
      bus.dividend  = dd;
      bus.divisor   = dv;
      @(posedge clk);
      #1;
      bus.start     = 1'b0;
      bus.is_signed = ~sgn;
      bus.dividend  = 32'hA5A5_5A5A;
      bus.divisor   = 32'h0000_0003;
      lat      = -1;
      busy_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = c;
            break;
         end
         busy_cnt += int'(bus.busy);
         if (c == glitch) begin
            bus.start    = 1'b1;
            bus.dividend = 32'd50;
            bus.divisor  = 32'd5;
         end else begin
            bus.start = 1'b0;
         end
      end
      bus.start = 1'b0;
   endtask

   task automatic check_result(input string name, input int lat, input int busy_cnt,
                               input logic [31:0] lo, input logic [31:0] hi, input logic dbz);
      check({name, ".latency"}, 32'(lat), 32'd35);
      check({name, ".busy_cycles"}, 32'(busy_cnt), 32'd34);
      check({name, ".busy_in_done"}, {31'd0, bus.busy}, 32'd0);
      check({name, ".LO"}, bus.divisionLOQuo, lo);
      check({name, ".HI"}, bus.divisionHIRes, hi);
      check({name, ".dbz"}, {31'd0, bus.div_by_zero}, {31'd0, dbz});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int bcnt;
      int done_seen;

      vecs[0]  = '{"u100_7",     1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
      vecs[1]  = '{"s-7_2",      1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0};
      vecs[2]  = '{"s7_-2",      1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         1'b0};
      vecs[3]  = '{"s-7_-2",     1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF,  1'b0};
      vecs[4]  = '{"umax_1",     1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0};
      vecs[5]  = '{"s_ovf",      1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0};
      vecs[6]  = '{"u5_9",       1'b0, 32'd5,         32'd9,         32'd0,         32'd5,         1'b0};
      vecs[7]  = '{"u_dbz",      1'b0, 32'h00001234,  32'd0,         32'hFFFFFFFF,  32'h00001234,  1'b1};
      vecs[8]  = '{"u8_2",       1'b0, 32'd8,         32'd2,         32'd4,         32'd0,         1'b0};
      vecs[9]  = '{"s_dbz",      1'b1, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF9,  1'b1};
      vecs[10] = '{"u_big_2",    1'b0, 32'hFFFFFFF9,  32'd2,         32'h7FFFFFFC,  32'd1,         1'b0};
      vecs[11] = '{"s100_7",     1'b1, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
      vecs[12] = '{"s-100_7",    1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0};

      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = 32'd0;
      bus.divisor   = 32'd0;

      repeat (3) @(negedge clk);
      check("rst.busy", {31'd0, bus.busy}, 32'd0);
      check("rst.done", {31'd0, bus.done}, 32'd0);
      check("rst.LO", bus.divisionLOQuo, 32'd0);
      check("rst.HI", bus.divisionHIRes, 32'd0);
      check("rst.dbz", {31'd0, bus.div_by_zero}, 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].sgn, vecs[i].dd, vecs[i].dv, 0, lat, bcnt);
         check_result(vecs[i].name, lat, bcnt, vecs[i].lo, vecs[i].hi, vecs[i].dbz);
      end

      // Mid-op start ignored, then start held through the DONE-cycle edge ignored.
      run_op(1'b0, 32'd100, 32'd7, 5, lat, bcnt);
      check_result("proto", lat, bcnt, 32'd14, 32'd2, 1'b0);
      bus.start    = 1'b1;
      bus.dividend = 32'd50;
      bus.divisor  = 32'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("proto.no_accept_busy", {31'd0, bus.busy}, 32'd0);
      check("proto.no_accept_done", {31'd0, bus.done}, 32'd0);
      check("proto.hold_LO", bus.divisionLOQuo, 32'd14);
      check("proto.hold_HI", bus.divisionHIRes, 32'd2);
      run_op(1'b0, 32'd10, 32'd3, 0, lat, bcnt);
      check_result("proto.next", lat, bcnt, 32'd3, 32'd1, 1'b0);

      // Reset in the middle of ITER.
      @(negedge clk);
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.dividend  = 32'd100;
      bus.divisor   = 32'd7;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
      end
      check("rmid.busy_before", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rmid.busy", {31'd0, bus.busy}, 32'd0);
      check("rmid.done", {31'd0, bus.done}, 32'd0);
      check("rmid.LO", bus.divisionLOQuo, 32'd0);
      check("rmid.HI", bus.divisionHIRes, 32'd0);
      check("rmid.dbz", {31'd0, bus.div_by_zero}, 32'd0);
      done_seen = 0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         done_seen += int'(bus.done) + int'(bus.busy);
      end
      check("rmid.no_activity", 32'(done_seen), 32'd0);
      run_op(1'b0, 32'd100, 32'd7, 0, lat, bcnt);
      check_result("rmid.after", lat, bcnt, 32'd14, 32'd2, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
